// File: rtl/nrisc_sequenciador.sv
// nrisc_sequenciador: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit nRisc core.
// Optional NRISC_PERF_EN adds retired-instruction and active-cycle counters.
`default_nettype none

module nrisc_sequenciador #(
    parameter int MEM_WAIT_MAX = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_jump,
    input  logic             i_ler_mem,
    input  logic             i_escreve_mem,
    input  logic             i_branch,
    input  logic             i_escreve_reg,
    input  logic             i_encerra,
    input  logic             i_ula_zero,
    input  logic             i_imem_ack,
    input  logic             i_dmem_ack,
    output logic             o_imem_req,
    output logic             o_ir_load,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic             o_mdr_load,
    output logic             o_reg_we,
    output logic             o_pc_inc,
    output logic             o_pc_load,
    output logic [2:0]       o_estado,
    output logic             o_parado,
    output logic             o_erro
`ifdef NRISC_PERF_EN
    ,
    output logic [CNT_W-1:0] o_instr_ret,
    output logic [CNT_W-1:0] o_ciclos
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERRO   = 3'd6
    } state_t;

    localparam logic [7:0] c_WAIT_MAX  = 8'(MEM_WAIT_MAX);
    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    if ((MEM_WAIT_MAX < 1) || (MEM_WAIT_MAX > 255) || (CNT_W < 1)) begin : g_bad_param
        $error("nrisc_sequenciador: parameter out of range");
    end

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait;
    logic       w_at_limit;
    logic       w_imem_req, w_ir_load, w_dmem_req, w_dmem_we;
    logic       w_mdr_load, w_reg_we, w_pc_inc, w_pc_load;

    assign w_at_limit = (r_wait == c_WAIT_LAST);

    always_comb begin
        w_next     = r_state;
        w_imem_req = 1'b0;
        w_ir_load  = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_mdr_load = 1'b0;
        w_reg_we   = 1'b0;
        w_pc_inc   = 1'b0;
        w_pc_load  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (i_imem_ack) begin
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end else if (w_at_limit) begin
                    w_next = S_ERRO;
                end
            end
            S_DECODE: begin
                w_next = i_encerra ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (i_jump || (i_branch && i_ula_zero)) begin
                    w_pc_load = 1'b1;
                    w_next    = S_FETCH;
                end else if (i_ler_mem || i_escreve_mem) begin
                    w_next = S_MEM;
                end else if (i_escreve_reg) begin
                    w_next = S_WB;
                end else begin
                    w_pc_inc = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_MEM: begin
                // A simultaneous read/write request is treated as a read.
                w_dmem_req = 1'b1;
                w_dmem_we  = i_escreve_mem & ~i_ler_mem;
                if (i_dmem_ack) begin
                    if (i_ler_mem) begin
                        w_mdr_load = 1'b1;
                        w_next     = S_WB;
                    end else begin
                        w_pc_inc = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else if (w_at_limit) begin
                    w_next = S_ERRO;
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_pc_inc = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            S_ERRO:  w_next = S_ERRO;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= 8'd0;
            end else if (((r_state == S_FETCH) || (r_state == S_MEM)) && (r_wait != c_WAIT_MAX)) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    // Enables are gated by reset so they fall the moment rst_n drops.
    assign o_imem_req = w_imem_req & rst_n;
    assign o_ir_load  = w_ir_load  & rst_n;
    assign o_dmem_req = w_dmem_req & rst_n;
    assign o_dmem_we  = w_dmem_we  & rst_n;
    assign o_mdr_load = w_mdr_load & rst_n;
    assign o_reg_we   = w_reg_we   & rst_n;
    assign o_pc_inc   = w_pc_inc   & rst_n;
    assign o_pc_load  = w_pc_load  & rst_n;
    assign o_estado   = r_state;
    assign o_parado   = (r_state == S_HALT);
    assign o_erro     = (r_state == S_ERRO);

`ifdef NRISC_PERF_EN
    logic [CNT_W-1:0] r_instr_ret;
    logic [CNT_W-1:0] r_ciclos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_ret <= '0;
            r_ciclos    <= '0;
        end else begin
            if (w_pc_inc || w_pc_load) begin
                r_instr_ret <= r_instr_ret + 1'b1;
            end
            if ((r_state != S_HALT) && (r_state != S_ERRO)) begin
                r_ciclos <= r_ciclos + 1'b1;
            end
        end
    end

    assign o_instr_ret = r_instr_ret;
    assign o_ciclos    = r_ciclos;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nrisc_sequenciador.sv
// Scoreboard bench for nrisc_sequenciador: instruction-level reference model, random + directed programs.
`default_nettype none

module tb_nrisc_sequenciador;
    localparam int MAX = 16;
    localparam int CW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic jump, ler, esc, branch, ereg, enc, zero, iack, dack;
    logic imem_req, ir_load, dmem_req, dmem_we, mdr_load, reg_we, pc_inc, pc_load, parado, erro;
    logic [2:0] estado;
`ifdef NRISC_PERF_EN
    logic [CW-1:0] instr_ret, ciclos;
`endif

    nrisc_sequenciador #(.MEM_WAIT_MAX(MAX), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_jump(jump), .i_ler_mem(ler), .i_escreve_mem(esc), .i_branch(branch),
        .i_escreve_reg(ereg), .i_encerra(enc), .i_ula_zero(zero),
        .i_imem_ack(iack), .i_dmem_ack(dack),
        .o_imem_req(imem_req), .o_ir_load(ir_load), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
        .o_mdr_load(mdr_load), .o_reg_we(reg_we), .o_pc_inc(pc_inc), .o_pc_load(pc_load),
        .o_estado(estado), .o_parado(parado), .o_erro(erro)
`ifdef NRISC_PERF_EN
        , .o_instr_ret(instr_ret), .o_ciclos(ciclos)
`endif
    );

    typedef struct packed {
        logic [12:0]   sig;
        logic [CW-1:0] ir;
        logic [CW-1:0] cy;
    } exp_t;

    exp_t          q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [CW-1:0] m_ir = '0;
    logic [CW-1:0] m_cy = '0;
    logic [12:0]   act;

    assign act = {imem_req, ir_load, dmem_req, dmem_we, mdr_load, reg_we, pc_inc, pc_load,
                  estado, parado, erro};

    // Expected output vector for one cycle: enables, state code, and the derived status flags.
    function automatic logic [12:0] mk(input logic ireq, irl, dreq, dwe, mdr, rwe, pinc, pld,
                                       input logic [2:0] st);
        return {ireq, irl, dreq, dwe, mdr, rwe, pinc, pld, st, st == 3'd5, st == 3'd6};
    endfunction

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            n_vec++;
            if (act !== x.sig) begin
                n_err++;
                $display("FAIL outputs vec %0d: got %b want %b (req,irl,dreq,dwe,mdr,rwe,inc,ld,st,par,err)",
                         n_vec, act, x.sig);
            end
`ifdef NRISC_PERF_EN
            if (instr_ret !== x.ir || ciclos !== x.cy) begin
                n_err++;
                $display("FAIL perf vec %0d: got ret=%0d cyc=%0d want ret=%0d cyc=%0d",
                         n_vec, instr_ret, ciclos, x.ir, x.cy);
            end
`endif
        end
    end

    task automatic step(input logic [12:0] e);
        exp_t x;
        if (!rst_n) begin
            m_ir = '0;
            m_cy = '0;
        end
        x.sig = e;
        x.ir  = m_ir;
        x.cy  = m_cy;
        q.push_back(x);
        if (rst_n) begin
            if (e[4:2] != 3'd5 && e[4:2] != 3'd6) m_cy = m_cy + 1'b1;
            if (e[6] || e[5]) m_ir = m_ir + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_dc();
        {jump, ler, esc, branch, ereg, enc, zero, iack, dack} = 9'($urandom);
    endtask

    task automatic set_ctl(input logic j, br, z, lm, em, rg, en);
        jump = j; branch = br; zero = z; ler = lm; esc = em; ereg = rg; enc = en;
    endtask

    task automatic hold(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            rand_dc();
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, st));
        end
    endtask

    task automatic reset_cycle();
        rand_dc();
        dack  = 1'b1;
        rst_n = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        rst_n = 1'b1;
    endtask

    // One instruction from fetch to retirement, with fw/mw wait states and optional reset at MEM wait rst_mem.
    task automatic run_instr(input logic j, br, z, lm, em, rg, en, input int fw, mw, rst_mem);
        logic rd, we;
        for (int i = 0; i <= fw; i++) begin
            rand_dc();
            iack = (i == fw);
            step(mk(1, iack, 0, 0, 0, 0, 0, 0, 3'd0));
            if (i == MAX - 1 && i != fw) begin
                hold(3'd6, 5);
                reset_cycle();
                return;
            end
        end
        rand_dc();
        set_ctl(j, br, z, lm, em, rg, en);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd1));
        if (en) begin
            hold(3'd5, 20);
            reset_cycle();
            return;
        end
        rand_dc();
        set_ctl(j, br, z, lm, em, rg, en);
        if (j || (br && z)) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 1, 3'd2));
            return;
        end
        if (!(lm || em)) begin
            step(mk(0, 0, 0, 0, 0, 0, !rg, 0, 3'd2));
            if (rg) begin
                rand_dc();
                step(mk(0, 0, 0, 0, 0, 1, 1, 0, 3'd4));
            end
            return;
        end
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd2));
        rd = lm;
        we = em && !lm;
        for (int i = 0; i <= mw; i++) begin
            rand_dc();
            set_ctl(j, br, z, lm, em, rg, en);
            if (i == rst_mem) begin
                reset_cycle();
                return;
            end
            dack = (i == mw);
            step(mk(0, 0, 1, we, dack && rd, 0, dack && !rd, 0, 3'd3));
            if (i == MAX - 1 && i != mw) begin
                hold(3'd6, 5);
                reset_cycle();
                return;
            end
        end
        if (rd) begin
            rand_dc();
            step(mk(0, 0, 0, 0, 0, 1, 1, 0, 3'd4));
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 39));
        if (r == 0) return MAX;
        if (r == 1) return MAX - 1;
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        rst_n = 1'b0;
        {jump, ler, esc, branch, ereg, enc, zero, iack, dack} = '0;
        @(posedge clk);
        #1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0));
        rst_n = 1'b1;

        run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, -1);       // ALU op
        run_instr(0, 0, 0, 1, 0, 1, 0, 0, 2, -1);       // load, 2 waits
        run_instr(0, 0, 0, 0, 1, 0, 0, 1, 0, -1);       // store
        run_instr(0, 0, 0, 1, 1, 1, 0, 0, 1, -1);       // read wins over write
        run_instr(0, 1, 1, 0, 0, 1, 0, 0, 0, -1);       // branch taken
        run_instr(0, 1, 0, 0, 0, 0, 0, 0, 0, -1);       // branch untaken
        run_instr(1, 0, 0, 1, 1, 1, 0, 0, 0, -1);       // jump beats mem
        run_instr(0, 0, 0, 0, 0, 0, 0, 2, 0, -1);       // nop
        run_instr(0, 0, 0, 0, 0, 1, 0, MAX - 1, 0, -1); // ack on the last allowed fetch cycle
        run_instr(0, 0, 0, 0, 0, 1, 0, MAX, 0, -1);     // fetch timeout
        run_instr(0, 0, 0, 1, 0, 1, 0, 0, MAX - 1, -1);
        run_instr(0, 0, 0, 0, 1, 0, 0, 0, MAX, -1);     // mem timeout
        run_instr(1, 0, 0, 0, 0, 0, 1, 0, 0, -1);       // halt beats jump
        run_instr(0, 0, 0, 1, 0, 1, 0, 0, 5, 2);        // reset mid-MEM
        run_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, -1);

        for (int k = 0; k < 300; k++) begin
            int fw, mw, rm;
            fw = pick_wait();
            mw = pick_wait();
            rm = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 30) == 0,
                      fw, mw, rm);
        end

        @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
